// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads words from a synchronous program memory,
// hands each to the processor with a Run pulse and waits for Done under a watchdog.
module instr_fetch #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int          TIMEOUT   = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  input  logic              Stop,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [15:0]       MemData,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Error,
  output logic [15:0]       Count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, READ, ISSUE, WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       din;
  logic              mem_rd;
  logic              run;
  logic              busy;
  logic              halted;
  logic              error;
  logic [15:0]       count;
  logic              stop_latch;
  logic [WD_W-1:0]   wd;

  // NOTE: all state is updated with non-blocking assignments in one clocked block, so
  // every branch reads the pre-edge values and the single-cycle strobes fall by default.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= '0;
      din        <= '0;
      mem_rd     <= 1'b0;
      run        <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
      stop_latch <= 1'b0;
      wd         <= '0;
    end else begin
      mem_rd <= 1'b0;
      run    <= 1'b0;
      if (state != IDLE && Stop)
        stop_latch <= 1'b1;

      case (state)
        IDLE: begin
          if (Start) begin
            pc         <= StartAddr;
            halted     <= 1'b0;
            error      <= 1'b0;
            stop_latch <= 1'b0;
            state      <= ADDR;
            mem_rd     <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ADDR: state <= READ;

        READ: begin
          // The halt word is swallowed here; the processor never sees it.
          if (MemData == HALT_WORD) begin
            halted <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
          end else begin
            din   <= MemData;
            state <= ISSUE;
            run   <= 1'b1;
          end
        end

        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end

        WAIT: begin
          wd <= wd + 1'b1;
          if (Done) begin
            if (count != 16'hFFFF)
              count <= count + 1'b1;
            if (stop_latch || Stop || pc == LastAddr) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              pc     <= pc + 1'b1;
              state  <= ADDR;
              mem_rd <= 1'b1;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign MemAddr = pc;
  assign MemRd   = mem_rd;
  assign DIN     = din;
  assign Run     = run;
  assign Busy    = busy;
  assign Halted  = halted;
  assign Error   = error;
  assign Count   = count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of whole-program runs plus
// hand-written sequences for stop, watchdog timeout and reset-during-wait.
module tb_instr_fetch;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [7:0]  StartAddr;
  logic [7:0]  LastAddr;
  logic        Stop;
  logic [7:0]  MemAddr;
  logic        MemRd;
  logic [15:0] MemData;
  logic [15:0] DIN;
  logic        Run;
  logic        done_w;
  logic        Busy;
  logic        Halted;
  logic        Error;
  logic [15:0] Count;

  logic        resp_done;
  logic        force_done;
  int          resp_n;
  int          resp_limit;

  logic [15:0] mem [256];
  logic [7:0]  run_addr_q [$];
  logic [15:0] run_din_q [$];
  int          rd_cnt;

  int total;
  int bad;

  assign done_w = resp_done | force_done;

  instr_fetch #(.ADDR_W(8), .HALT_WORD(16'hFFFF), .TIMEOUT(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .LastAddr  (LastAddr),
    .Stop      (Stop),
    .MemAddr   (MemAddr),
    .MemRd     (MemRd),
    .MemData   (MemData),
    .DIN       (DIN),
    .Run       (Run),
    .Done      (done_w),
    .Busy      (Busy),
    .Halted    (Halted),
    .Error     (Error),
    .Count     (Count)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Synchronous program memory: data appears the cycle after the read strobe.
  initial MemData = '0;
  always @(posedge Clock)
    if (MemRd) MemData <= mem[MemAddr];

  // Observer of read strobes and issued instructions.
  initial begin
    rd_cnt = 0;
    forever begin
      @(negedge Clock);
      if (Run) begin
        run_addr_q.push_back(MemAddr);
        run_din_q.push_back(DIN);
      end
      if (MemRd) rd_cnt++;
    end
  end

  // Processor model: answers Done 2, 3, 4 cycles after successive Runs.
  initial begin
    int d;
    resp_done = 1'b0;
    resp_n    = 0;
    forever begin
      @(negedge Clock);
      if (Run && resp_n < resp_limit) begin
        d = 2 + (resp_n % 3);
        resp_n++;
        repeat (d - 1) @(negedge Clock);
        resp_done = 1'b1;
        @(negedge Clock);
        resp_done = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic start_run(input logic [7:0] s, input logic [7:0] l);
    StartAddr = s;
    LastAddr  = l;
    Start     = 1'b1;
    @(negedge Clock);
    Start     = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy && n < 300) begin
      @(negedge Clock);
      n++;
    end
    check(name, Busy, 0);
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!Run && n < 60);
    check(name, Run, 1);
  endtask

  typedef struct {
    logic [7:0]        start_addr;
    logic [7:0]        last_addr;
    int                exp_runs;
    int                exp_rds;
    logic [15:0]       exp_count;
    logic              exp_halted;
    logic [0:3][7:0]   exp_addr;
    logic [0:3][15:0]  exp_din;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int run_base;
    int rd_base;
    total      = 0;
    bad        = 0;
    Reset      = 1'b1;
    Start      = 1'b0;
    Stop       = 1'b0;
    StartAddr  = '0;
    LastAddr   = '0;
    force_done = 1'b0;
    resp_limit = 0;

    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'h1205;
    mem[1] = 16'h1403;
    mem[2] = 16'h4402;
    mem[5] = 16'hFFFF;

    vecs[0] = '{8'h00, 8'h02, 3, 3, 16'd3, 1'b0,
                {8'h00, 8'h01, 8'h02, 8'h00}, {16'h1205, 16'h1403, 16'h4402, 16'h0000}};
    vecs[1] = '{8'h04, 8'h09, 1, 2, 16'd1, 1'b1,
                {8'h04, 8'h00, 8'h00, 8'h00}, {16'h1004, 16'h0000, 16'h0000, 16'h0000}};
    vecs[2] = '{8'hFE, 8'h01, 4, 4, 16'd4, 1'b0,
                {8'hFE, 8'hFF, 8'h00, 8'h01}, {16'h10FE, 16'h10FF, 16'h1205, 16'h1403}};
    vecs[3] = '{8'h07, 8'h07, 1, 1, 16'd1, 1'b0,
                {8'h07, 8'h00, 8'h00, 8'h00}, {16'h1007, 16'h0000, 16'h0000, 16'h0000}};
    vecs[4] = '{8'h03, 8'h06, 2, 3, 16'd2, 1'b1,
                {8'h03, 8'h04, 8'h00, 8'h00}, {16'h1003, 16'h1004, 16'h0000, 16'h0000}};

    // Reset state
    @(negedge Clock);
    do_reset();
    check("rst_busy", Busy, 0);
    check("rst_run", Run, 0);
    check("rst_memrd", MemRd, 0);
    check("rst_din", DIN, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_count", Count, 0);
    check("rst_halted", Halted, 0);
    check("rst_error", Error, 0);

    // Table-driven whole-program runs
    for (int v = 0; v < 5; v++) begin
      do_reset();
      resp_limit = resp_n + 1000;
      run_base   = run_addr_q.size();
      rd_base    = rd_cnt;
      start_run(vecs[v].start_addr, vecs[v].last_addr);
      check($sformatf("v%0d_lat_memrd", v), MemRd, 1);
      check($sformatf("v%0d_lat_addr", v), MemAddr, vecs[v].start_addr);
      check($sformatf("v%0d_lat_busy", v), Busy, 1);
      @(negedge Clock);
      check($sformatf("v%0d_lat_rd_drop", v), MemRd, 0);
      @(negedge Clock);
      check($sformatf("v%0d_lat_run", v), Run, 1);
      wait_idle($sformatf("v%0d_idle", v));
      check($sformatf("v%0d_runs", v), run_addr_q.size() - run_base, vecs[v].exp_runs);
      check($sformatf("v%0d_rds", v), rd_cnt - rd_base, vecs[v].exp_rds);
      check($sformatf("v%0d_count", v), Count, vecs[v].exp_count);
      check($sformatf("v%0d_halted", v), Halted, vecs[v].exp_halted);
      check($sformatf("v%0d_error", v), Error, 0);
      for (int i = 0; i < vecs[v].exp_runs; i++) begin
        if (run_base + i < run_addr_q.size()) begin
          check($sformatf("v%0d_addr%0d", v, i), run_addr_q[run_base + i], vecs[v].exp_addr[i]);
          check($sformatf("v%0d_din%0d", v, i), run_din_q[run_base + i], vecs[v].exp_din[i]);
        end
      end
    end

    // Stop during ISSUE of the first instruction
    do_reset();
    resp_limit = resp_n + 1000;
    run_base   = run_addr_q.size();
    rd_base    = rd_cnt;
    start_run(8'h00, 8'h07);
    wait_run("stop_run");
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
    wait_idle("stop_idle");
    repeat (3) @(negedge Clock);
    check("stop_runs", run_addr_q.size() - run_base, 1);
    check("stop_rds", rd_cnt - rd_base, 1);
    check("stop_count", Count, 1);

    // Done withheld on the second instruction: watchdog timeout
    do_reset();
    resp_limit = resp_n + 1;
    run_base   = run_addr_q.size();
    start_run(8'h00, 8'h07);
    wait_run("to_run1");
    wait_run("to_run2");
    repeat (8) @(negedge Clock);
    check("to_err_early", Error, 0);
    check("to_busy_early", Busy, 1);
    @(negedge Clock);
    check("to_err", Error, 1);
    check("to_busy", Busy, 0);
    check("to_count", Count, 1);
    check("to_runs", run_addr_q.size() - run_base, 2);

    // Reset in WAIT alongside Done, then a clean restart
    do_reset();
    resp_limit = resp_n + 1;
    start_run(8'h00, 8'h07);
    wait_run("rw_run1");
    wait_run("rw_run2");
    @(negedge Clock);
    Reset      = 1'b1;
    force_done = 1'b1;
    @(negedge Clock);
    Reset      = 1'b0;
    force_done = 1'b0;
    check("rw_busy", Busy, 0);
    check("rw_run", Run, 0);
    check("rw_memrd", MemRd, 0);
    check("rw_din", DIN, 0);
    check("rw_memaddr", MemAddr, 0);
    check("rw_count", Count, 0);
    check("rw_halted", Halted, 0);
    check("rw_error", Error, 0);
    @(negedge Clock);
    check("rw_run_after", Run, 0);
    check("rw_busy_after", Busy, 0);
    Stop = 1'b1;
    @(negedge Clock);
    Stop = 1'b0;
    resp_limit = resp_n + 1000;
    run_base   = run_addr_q.size();
    start_run(8'h02, 8'h03);
    wait_idle("rw_idle");
    check("rw_restart_runs", run_addr_q.size() - run_base, 2);
    if (run_addr_q.size() - run_base == 2) begin
      check("rw_restart_addr0", run_addr_q[run_base], 8'h02);
      check("rw_restart_din1", run_din_q[run_base + 1], 16'h1003);
    end
    check("rw_restart_count", Count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
